// File: rtl/menu_nav_ctrl.sv
// menu_nav_ctrl: debounced three-button menu navigation with a wrap-around
// cursor, a confirm/lock handshake towards the application, and a
// frame-latched per-scanline highlight flag for the text renderer.
// Optional build macro: MENU_AUTOREPEAT_EN enables auto-repeat of held up/down.
module menu_nav_ctrl #(
  parameter int NUM_ITEMS       = 4,
  parameter int ROW_W           = $clog2(NUM_ITEMS),
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MENU_ROW0       = 2,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_sel_i,
  input  logic             frame_start_i,
  input  logic [9:0]       vpos_i,
  input  logic             ack_i,
  output logic [ROW_W-1:0] cursor_o,
  output logic [ROW_W-1:0] highlight_row_o,
  output logic             highlight_o,
  output logic             choice_valid_o,
  output logic [ROW_W-1:0] choice_o,
  output logic             locked_o
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ITEMS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_ZERO  = {ROW_W{1'b0}};

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, state_next;

  // bit 0 = up, bit 1 = down, bit 2 = select
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       level;
  logic [2:0]       level_d;
  logic [2:0]       press;
  logic [CNT_W-1:0] deb_cnt [3];
  logic             up_ev;
  logic             dn_ev;
  logic             sel_ev;
  logic [ROW_W-1:0] cursor_next;
  logic [6:0]       hl_sum;
  logic             hl_match;

  assign raw = {btn_sel_i, btn_down_i, btn_up_i};

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncers: a level is accepted once the input has disagreed with it for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level   <= 3'b000;
      level_d <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= {CNT_W{1'b0}};
    end else begin
      level_d <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= {CNT_W{1'b0}};
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= {CNT_W{1'b0}};
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign press  = level & ~level_d;
  assign sel_ev = press[2];

`ifdef MENU_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt;
  logic             hold_one;
  logic             rep_pulse;

  assign hold_one  = level[0] ^ level[1];
  assign rep_pulse = (state == BROWSE) && hold_one && (rep_cnt == REP_LAST);

  // Repeat timer: runs only while exactly one of up/down is held in BROWSE, restarts on each press
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt <= {CNT_W{1'b0}};
    end else if ((state == BROWSE) && hold_one && !(press[0] || press[1])) begin
      if (rep_cnt == REP_LAST) rep_cnt <= {CNT_W{1'b0}};
      else                     rep_cnt <= rep_cnt + CNT_ONE;
    end else begin
      rep_cnt <= {CNT_W{1'b0}};
    end
  end

  assign up_ev = press[0] | (rep_pulse & level[0]);
  assign dn_ev = press[1] | (rep_pulse & level[1]);
`else
  assign up_ev = press[0];
  assign dn_ev = press[1];
`endif

  // Next-state and next-cursor decode; select beats up/down, up+down together cancel
  always_comb begin
    state_next  = state;
    cursor_next = cursor_o;
    case (state)
      BROWSE: begin
        if (sel_ev) begin
          state_next = CONFIRM;
        end else if (up_ev && !dn_ev) begin
          cursor_next = (cursor_o == ROW_ZERO) ? ROW_LAST : (cursor_o - ROW_ONE);
        end else if (dn_ev && !up_ev) begin
          cursor_next = (cursor_o == ROW_LAST) ? ROW_ZERO : (cursor_o + ROW_ONE);
        end else begin
          cursor_next = cursor_o;
        end
      end
      CONFIRM: begin
        state_next = LOCKED;
      end
      LOCKED: begin
        if (ack_i) state_next = BROWSE;
        else       state_next = LOCKED;
      end
      default: begin
        state_next = BROWSE;
      end
    endcase
  end

  // State register plus the registered cursor and choice handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= BROWSE;
      cursor_o       <= ROW_ZERO;
      choice_o       <= ROW_ZERO;
      choice_valid_o <= 1'b0;
      locked_o       <= 1'b0;
    end else begin
      state          <= state_next;
      cursor_o       <= cursor_next;
      choice_valid_o <= (state == CONFIRM);
      locked_o       <= (state_next == LOCKED);
      if (state == CONFIRM) choice_o <= cursor_o;
      else                  choice_o <= choice_o;
    end
  end

  // A 7-bit sum keeps rows past 63 from aliasing onto low scanlines
  assign hl_sum   = 7'(MENU_ROW0) + 7'(highlight_row_o);
  assign hl_match = (hl_sum[6] == 1'b0) && (hl_sum[5:0] == vpos_i[9:4]);

  // Display side: latch the cursor once per frame and flag the highlighted text row
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      highlight_row_o <= ROW_ZERO;
      highlight_o     <= 1'b0;
    end else begin
      if (frame_start_i) highlight_row_o <= cursor_o;
      else               highlight_row_o <= highlight_row_o;
      highlight_o <= hl_match;
    end
  end

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Self-checking bench for menu_nav_ctrl with a behavioural menu model.
// Build with MENU_AUTOREPEAT_EN defined to also exercise auto-repeat.
module tb_menu_nav_ctrl;

  localparam int NUM   = 4;
  localparam int DEB   = 4;
  localparam int ROW0  = 2;
  localparam int REP_T = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic       btn_sel_i = 1'b0;
  logic       frame_start_i = 1'b0;
  logic [9:0] vpos_i = 10'd0;
  logic       ack_i = 1'b0;
  logic [1:0] cursor_o;
  logic [1:0] highlight_row_o;
  logic       highlight_o;
  logic       choice_valid_o;
  logic [1:0] choice_o;
  logic       locked_o;

  int checks = 0;
  int errors = 0;

  // behavioural model of the menu
  int m_cursor = 0;
  int m_hr     = 0;
  int m_choice = 0;
  bit m_locked = 1'b0;

  // observations and expectations from the last press
  int obs_pulses;
  int obs_choice;
  int exp_pulses;

  menu_nav_ctrl #(
    .NUM_ITEMS(NUM), .DEBOUNCE_CYCLES(DEB), .MENU_ROW0(ROW0), .REPEAT_CYCLES(REP_T)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_up_i(btn_up_i), .btn_down_i(btn_down_i),
    .btn_sel_i(btn_sel_i), .frame_start_i(frame_start_i), .vpos_i(vpos_i), .ack_i(ack_i),
    .cursor_o(cursor_o), .highlight_row_o(highlight_row_o), .highlight_o(highlight_o),
    .choice_valid_o(choice_valid_o), .choice_o(choice_o), .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Hold the given raw buttons for 'hold' cycles, release, let everything settle.
  task automatic press(input bit up, input bit dn, input bit sel, input int hold);
    int n;
    int pulses;
    int ch;
    pulses = 0;
    ch = 0;
    btn_up_i = up; btn_down_i = dn; btn_sel_i = sel;
    for (int i = 0; i < hold + 14; i++) begin
      if (i == hold) begin
        btn_up_i = 1'b0; btn_down_i = 1'b0; btn_sel_i = 1'b0;
      end
      tick();
      if (choice_valid_o === 1'b1) begin
        pulses++;
        ch = int'(choice_o);
      end
    end
    obs_pulses = pulses;
    obs_choice = ch;
    exp_pulses = 0;
    if (!m_locked) begin
      if (sel) begin
        m_choice = m_cursor;
        m_locked = 1'b1;
        exp_pulses = 1;
      end else if (up && dn) begin
        exp_pulses = 0;
      end else if (up || dn) begin
        n = 1;
`ifdef MENU_AUTOREPEAT_EN
        n = 1 + (hold - 1) / REP_T;
`endif
        for (int k = 0; k < n; k++) begin
          if (up) m_cursor = (m_cursor + NUM - 1) % NUM;
          else    m_cursor = (m_cursor + 1) % NUM;
        end
      end
    end
  endtask

  task automatic goto(input int target);
    while (m_cursor != target) press(1'b0, 1'b1, 1'b0, $urandom_range(5, 8));
  endtask

  task automatic pulse_frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    m_hr = m_cursor;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    checks++; if (cursor_o !== 2'd0) begin errors++; $display("FAIL reset_cursor got %0d expected 0", cursor_o); end
    checks++; if (highlight_row_o !== 2'd0) begin errors++; $display("FAIL reset_hrow got %0d expected 0", highlight_row_o); end
    checks++; if (highlight_o !== 1'b0) begin errors++; $display("FAIL reset_highlight got %0d expected 0", highlight_o); end
    checks++; if (choice_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d expected 0", choice_valid_o); end
    checks++; if (choice_o !== 2'd0) begin errors++; $display("FAIL reset_choice got %0d expected 0", choice_o); end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d expected 0", locked_o); end
    tick(); tick();
    rst_ni = 1'b1;
    tick(); tick();
  endtask

  task automatic test_glitch();
    btn_down_i = 1'b1;
    tick(); tick(); tick();
    btn_down_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (int'(cursor_o) !== 0) begin errors++; $display("FAIL glitch_cursor got %0d expected 0", cursor_o); end
  endtask

  task automatic test_navigation();
    int r;
    for (int p = 0; p < 5; p++) begin
      if (p < 4) press(1'b0, 1'b1, 1'b0, 10);
      else       press(1'b1, 1'b0, 1'b0, 8);
      checks++;
      if (int'(cursor_o) !== m_cursor) begin
        errors++; $display("FAIL nav_fixed_%0d got %0d expected %0d", p, cursor_o, m_cursor);
      end
    end
    for (int p = 0; p < 12; p++) begin
      r = $urandom_range(0, 2);
      press(r != 1, r != 0, 1'b0, $urandom_range(5, 8));
      checks++;
      if (int'(cursor_o) !== m_cursor || obs_pulses != 0) begin
        errors++; $display("FAIL nav_rand_%0d btn %0d got cursor %0d pulses %0d expected %0d pulses 0",
                           p, r, cursor_o, obs_pulses, m_cursor);
      end
    end
  endtask

  task automatic test_highlight();
    int v;
    bit exp;
    if (m_cursor == 2) goto(3);
    goto(2);
    checks++; if (int'(highlight_row_o) !== m_hr) begin errors++; $display("FAIL hrow_before_frame got %0d expected %0d", highlight_row_o, m_hr); end
    pulse_frame();
    checks++; if (int'(highlight_row_o) !== 2) begin errors++; $display("FAIL hrow_after_frame got %0d expected 2", highlight_row_o); end
    vpos_i = 10'd64; tick();
    checks++; if (highlight_o !== 1'b1) begin errors++; $display("FAIL highlight_row4 got %0d expected 1", highlight_o); end
    vpos_i = 10'd80; tick();
    checks++; if (highlight_o !== 1'b0) begin errors++; $display("FAIL highlight_row5 got %0d expected 0", highlight_o); end
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) v = (ROW0 + m_hr + int'($urandom_range(0, 2)) - 1) * 16 + int'($urandom_range(0, 15));
      else            v = $urandom_range(0, 1023);
      vpos_i = v[9:0];
      tick();
      exp = ((v / 16) == (ROW0 + m_hr));
      checks++;
      if (highlight_o !== exp) begin errors++; $display("FAIL highlight_rand vpos %0d got %0d expected %0d", v, highlight_o, exp); end
    end
    press(1'b0, 1'b1, 1'b0, 6);
    checks++; if (int'(highlight_row_o) !== m_hr || int'(cursor_o) !== 3) begin
      errors++; $display("FAIL hrow_midframe got %0d cursor %0d expected %0d cursor 3", highlight_row_o, cursor_o, m_hr);
    end
    pulse_frame();
    checks++; if (int'(highlight_row_o) !== 3) begin errors++; $display("FAIL hrow_next_frame got %0d expected 3", highlight_row_o); end
  endtask

  task automatic test_select();
    goto(1);
    press(1'b1, 1'b0, 1'b1, 6);
    checks++; if (obs_pulses != exp_pulses) begin errors++; $display("FAIL sel_pulses got %0d expected %0d", obs_pulses, exp_pulses); end
    checks++; if (obs_choice != m_choice || int'(choice_o) !== m_choice) begin
      errors++; $display("FAIL sel_choice got %0d held %0d expected %0d", obs_choice, choice_o, m_choice);
    end
    checks++; if (int'(cursor_o) !== m_cursor) begin errors++; $display("FAIL sel_cursor got %0d expected %0d", cursor_o, m_cursor); end
    checks++; if (locked_o !== m_locked) begin errors++; $display("FAIL sel_locked got %0d expected %0d", locked_o, m_locked); end
  endtask

  task automatic test_locked();
    press(1'b0, 1'b1, 1'b0, 6);
    checks++; if (int'(cursor_o) !== m_cursor || locked_o !== 1'b1) begin
      errors++; $display("FAIL locked_ignore got cursor %0d locked %0d expected %0d 1", cursor_o, locked_o, m_cursor);
    end
    press(1'b0, 1'b0, 1'b1, 6);
    checks++; if (obs_pulses != 0 || int'(choice_o) !== m_choice) begin
      errors++; $display("FAIL locked_sel got pulses %0d choice %0d expected 0 %0d", obs_pulses, choice_o, m_choice);
    end
    ack_i = 1'b1; tick(); ack_i = 1'b0; tick();
    m_locked = 1'b0;
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL ack_unlock got %0d expected 0", locked_o); end
    press(1'b0, 1'b1, 1'b0, 6);
    checks++; if (int'(cursor_o) !== m_cursor) begin errors++; $display("FAIL after_ack_cursor got %0d expected %0d", cursor_o, m_cursor); end
    ack_i = 1'b1; tick(); ack_i = 1'b0; tick();
    checks++; if (locked_o !== 1'b0 || int'(cursor_o) !== m_cursor) begin
      errors++; $display("FAIL ack_browse got locked %0d cursor %0d expected 0 %0d", locked_o, cursor_o, m_cursor);
    end
  endtask

  task automatic test_async_reset();
    goto(3);
    press(1'b0, 1'b0, 1'b1, 6);
    checks++; if (locked_o !== 1'b1 || int'(choice_o) !== 3) begin
      errors++; $display("FAIL pre_reset got locked %0d choice %0d expected 1 3", locked_o, choice_o);
    end
    pulse_frame();
    vpos_i = 10'(16 * (ROW0 + 3));
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({cursor_o, highlight_row_o, highlight_o, choice_valid_o, choice_o, locked_o} !== 9'd0) begin
      errors++; $display("FAIL async_reset got %0d %0d %0d %0d %0d %0d expected all 0",
                         cursor_o, highlight_row_o, highlight_o, choice_valid_o, choice_o, locked_o);
    end
    m_cursor = 0; m_hr = 0; m_choice = 0; m_locked = 1'b0;
    vpos_i = 10'd0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

`ifdef MENU_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int holds [3] = '{30, 22, 17};
    for (int i = 0; i < 3; i++) begin
      press(i == 2, i != 2, 1'b0, holds[i]);
      checks++;
      if (int'(cursor_o) !== m_cursor) begin
        errors++; $display("FAIL autorepeat_%0d got %0d expected %0d", i, cursor_o, m_cursor);
      end
    end
    press(1'b1, 1'b1, 1'b0, 20);
    checks++; if (int'(cursor_o) !== m_cursor) begin errors++; $display("FAIL autorepeat_both got %0d expected %0d", cursor_o, m_cursor); end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_navigation();
    test_highlight();
    test_select();
    test_locked();
    test_async_reset();
`ifdef MENU_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
